// File: rtl/matrix_pkg.sv
// matrix_pkg: shared geometry and state encoding for the dot-matrix scroller
package matrix_pkg;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 16;
    localparam int NUM_ROWS = 16;
    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;
endpackage

// File: rtl/barrel_rot16.sv
// barrel_rot16: combinational 16-bit rotate-left by a 4-bit amount
module barrel_rot16 (
    input  logic [15:0] d,
    input  logic [3:0]  n,
    output logic [15:0] q
);
    logic [15:0] s0, s1, s2;
    assign s0 = n[0] ? {d[14:0], d[15]}     : d;
    assign s1 = n[1] ? {s0[13:0], s0[15:14]} : s0;
    assign s2 = n[2] ? {s1[11:0], s1[15:12]} : s1;
    assign q  = n[3] ? {s2[7:0], s2[15:8]}   : s2;
endmodule

// File: rtl/matrix_scroller.sv
// matrix_scroller: loads a 16x16 frame from a row source and drives a horizontally rotating column word
module matrix_scroller
    import matrix_pkg::*;
#(
    parameter int STEP_TICKS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic [ROW_W-1:0] row_bin,
    input  logic             load_req,
    input  logic             run,
    input  logic             dir,
    output logic [ROW_W-1:0] src_row,
    input  logic [COL_W-1:0] src_col,
    output logic             busy,
    output logic [3:0]       offset,
    output logic [COL_W-1:0] col
);
    localparam int TW = $clog2(STEP_TICKS) + 1;

    state_t           state;
    logic [COL_W-1:0] frame [NUM_ROWS];
    logic [TW-1:0]    tick;
    logic [COL_W-1:0] rot;
    logic             last;

    assign last = tick == TW'(STEP_TICKS - 1);

    barrel_rot16 u_rot (.d(frame[row_bin]), .n(offset), .q(rot));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            src_row <= '0;
            busy    <= 1'b0;
            offset  <= '0;
            tick    <= '0;
            col     <= '0;
            for (int i = 0; i < NUM_ROWS; i++) frame[i] <= '0;
        end else begin
            case (state)
                IDLE: if (load_req) begin
                    state   <= LOAD;
                    busy    <= 1'b1;
                    src_row <= '0;
                end
                LOAD: begin
                    frame[src_row] <= src_col;
                    src_row        <= src_row + 1'b1;
                    if (src_row == ROW_W'(NUM_ROWS - 1)) begin
                        state  <= SHOW;
                        busy   <= 1'b0;
                        offset <= '0;
                        tick   <= '0;
                    end
                end
                SHOW: if (load_req) begin
                    state   <= LOAD;
                    busy    <= 1'b1;
                    src_row <= '0;
                    offset  <= '0;
                    tick    <= '0;
                    col     <= '0;
                end else begin
                    col <= rot;
                    if (run && scan_en) begin
                        tick <= last ? '0 : tick + 1'b1;
                        if (last) offset <= dir ? offset - 4'd1 : offset + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
